mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter: WAIT_MAX, default 15, maximum number of BUSY cycles without DAck before a bus error is declared.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 RegWriteM, MemWriteM  in  1 each  M-stage control signals from the EX/MEM register.
REQ-005 ResultSrcM  in  2  writeback select: 00 ALU result, 01 load data, 10 PC+4, 11 reserved (treated as ALU).
REQ-006 MemStrobeM  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-007 LdUnsignedM  in  1  load extension: 1 zero-extend, 0 sign-extend.
REQ-008 ALUResultM, WriteDataM, PCPlus4M  in  32 each  byte address/ALU value, store data, and PC+4.
REQ-009 RdM  in  5  destination register.
REQ-010 DReq, DWe  out  1 each  data-memory request and write enable.
REQ-011 DAddr  out  32  word-aligned address, equal to {ALUResultM[31:2],2'b00}.
REQ-012 DWData, DBe  out  32, 4  lane-replicated store data and byte enables.
REQ-013 DRData, DAck  in  32, 1  read data and completion; DRData is valid in the cycle DAck is high.
REQ-014 StallM  out  1  to hazard unit; holds F, D, E and the EX/MEM register.
REQ-015 MisalignM, BusErrW  out  1 each  misaligned-access flag (combinational) and one-cycle registered timeout pulse.
REQ-016 RegWriteW, RdW, ResultW  out  1, 5, 32  registered writeback outputs.

Function
REQ-017 A memory op is MemWriteM=1 or ResultSrcM=01.
REQ-018 Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. MisalignM=1, no DReq, StallM=0, RegWriteW<=0 next edge.
REQ-019 FSM states: IDLE, BUSY, DONE.
REQ-020 IDLE with an aligned memory op: StallM=1, next state BUSY.
REQ-021 BUSY: DReq=1, DWe=MemWriteM, StallM=1, wait counter increments.
REQ-022 BUSY with DAck=1: DRData latched, next state DONE.
REQ-023 BUSY with no DAck when counter=WAIT_MAX-1: next state DONE with error flag set.
REQ-024 DONE: StallM=0, W register captures, next state IDLE; if error flag set, RegWriteW<=0 and BusErrW<=1 for one cycle.
REQ-025 DAck outside BUSY is ignored.
REQ-026 Minimum memory-op latency is 3 cycles (IDLE, BUSY, DONE); a non-memory op takes 1 cycle, StallM=0.
REQ-027 While StallM=1, the W register loads a bubble: RegWriteW<=0, RdW and ResultW hold.
REQ-028 Store byte enables: byte DBe=0001<<addr[1:0], data byte replicated x4; half DBe=0011<<(2*addr[1]), halfword replicated x2; word DBe=1111.
REQ-029 Load: lane = DRData>>(8*addr[1:0]); byte/half extended to 32 bits per LdUnsignedM; word passes unchanged.
REQ-030 ResultW <= ALUResultM, load data, or PCPlus4M per ResultSrcM; RegWriteW <= RegWriteM; RdW <= RdM.
REQ-031 DReq, DWe and DBe are 0 outside BUSY.

Reset
REQ-032 rst=1 at a clock edge: FSM<=IDLE, counter<=0, error flag<=0, RegWriteW<=0, RdW<=0, ResultW<=0, BusErrW<=0.
REQ-033 rst has priority, including mid-BUSY; the pending access is abandoned and a late DAck is ignored.

Structure
REQ-034 Shared package rv_mem_pkg holds the FSM state type and the MemStrobe and ResultSrc encodings.
REQ-035 One combinational sub-module, lsu_align, performs store lane/byte-enable generation and load extraction.

Verification
REQ-036 Word store: addr 0x104, data 0xDEADBEEF, DAck in first BUSY cycle -> DBe=1111, DWData=0xDEADBEEF, StallM high for 2 cycles.
REQ-037 Signed byte load: addr 0x203, DRData=0x80FFFFFF -> ResultW=0xFFFFFF80; with LdUnsignedM=1 -> 0x00000080.
REQ-038 Half store: addr 0x2, data 0x1234ABCD -> DBe=1100, DWData=0xABCDABCD.
REQ-039 Misaligned word load: addr 0x6 -> MisalignM=1, DReq stays 0, RegWriteW=0.
REQ-040 No DAck for 15 BUSY cycles -> BusErrW pulses once, RegWriteW=0, FSM returns to IDLE.
REQ-041 rst asserted in the 3rd BUSY cycle, then DAck -> outputs at reset values, no writeback.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared encodings for the memory-access stage: FSM states, access size, writeback select.
// Pure type/function package, no timing of its own.
// No flow control.
package rv_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mem_state_e;

    typedef enum logic [1:0] {
        MS_BYTE = 2'b00,
        MS_HALF = 2'b01,
        MS_WORD = 2'b10,
        MS_RSVD = 2'b11
    } mem_strobe_e;

    typedef enum logic [1:0] {
        RS_ALU  = 2'b00,
        RS_LOAD = 2'b01,
        RS_PC4  = 2'b10,
        RS_RSVD = 2'b11
    } result_src_e;

    // Reserved size encoding behaves as a word access.
    function automatic logic addr_misaligned(input logic [1:0] strobe, input logic [1:0] addr_lo);
        logic mis;
        case (mem_strobe_e'(strobe))
            MS_BYTE: mis = 1'b0;
            MS_HALF: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Store lane replication / byte-enable generation and load lane extraction with extension.
// Purely combinational, zero latency.
// No flow control.
module lsu_align
    import rv_mem_pkg::*;
(
    input  logic [1:0]  strobe_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    input  logic        ld_unsigned_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o
);

    logic [31:0] lane;

    always_comb begin
        lane    = rdata_i >> {addr_lo_i, 3'b000};
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        ldata_o = rdata_i;
        case (mem_strobe_e'(strobe_i))
            MS_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                ldata_o = {{24{~ld_unsigned_i & lane[7]}}, lane[7:0]};
            end
            MS_HALF: begin
                be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
                ldata_o = {{16{~ld_unsigned_i & lane[15]}}, lane[15:0]};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                ldata_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// M stage of the pipeline: drives the data bus for loads/stores and registers the writeback.
// Non-memory op 1 cycle; memory op IDLE->BUSY->DONE, at least 3 cycles, timeout after WAIT_MAX BUSY cycles.
// Back-pressures the pipeline through StallM while a bus access is outstanding.
module mem_access_stage
    import rv_mem_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [1:0]  MemStrobeM,
    input  logic        LdUnsignedM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    input  logic [4:0]  RdM,
    output logic        DReq,
    output logic        DWe,
    output logic [31:0] DAddr,
    output logic [31:0] DWData,
    output logic [3:0]  DBe,
    input  logic [31:0] DRData,
    input  logic        DAck,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrW,
    output logic        RegWriteW,
    output logic [4:0]  RdW,
    output logic [31:0] ResultW
);

    localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

    mem_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        regwrite_q, regwrite_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] result_q, result_d;
    logic        bus_err_q, bus_err_d;

    logic        mem_op;
    logic        busy;
    logic [3:0]  be_lane;
    logic [31:0] ld_data;
    logic [31:0] wb_sel;

    // Load extraction works on the captured bus data so DONE sees a stable value.
    lsu_align u_align (
        .strobe_i      (MemStrobeM),
        .addr_lo_i     (ALUResultM[1:0]),
        .wdata_i       (WriteDataM),
        .rdata_i       (rdata_q),
        .ld_unsigned_i (LdUnsignedM),
        .be_o          (be_lane),
        .wdata_o       (DWData),
        .ldata_o       (ld_data)
    );

    always_comb begin
        mem_op    = MemWriteM | (result_src_e'(ResultSrcM) == RS_LOAD);
        MisalignM = mem_op & addr_misaligned(MemStrobeM, ALUResultM[1:0]);
        busy      = (state_q == ST_BUSY);
        StallM    = busy | ((state_q == ST_IDLE) & mem_op & ~MisalignM);
        DReq      = busy;
        DWe       = busy & MemWriteM;
        DBe       = busy ? be_lane : 4'b0000;
        DAddr     = {ALUResultM[31:2], 2'b00};

        case (result_src_e'(ResultSrcM))
            RS_LOAD: wb_sel = ld_data;
            RS_PC4:  wb_sel = PCPlus4M;
            default: wb_sel = ALUResultM;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                err_d = 1'b0;
                if (mem_op && !MisalignM) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (DAck) begin
                    rdata_d = DRData;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else if (cnt_q == CW'(WAIT_MAX - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        bus_err_d = (state_q == ST_DONE) & err_q;

        // Stalled cycles push a bubble into W while keeping the last result visible.
        if (StallM) begin
            regwrite_d = 1'b0;
            rd_d       = rd_q;
            result_d   = result_q;
        end else begin
            regwrite_d = RegWriteM & ~MisalignM & ~bus_err_d;
            rd_d       = RdM;
            result_d   = wb_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            result_q   <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            result_q   <= result_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign RegWriteW = regwrite_q;
    assign RdW       = rd_q;
    assign ResultW   = result_q;
    assign BusErrW   = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: inputs change and outputs are sampled 2ns after each rising edge.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, MemWriteM, LdUnsignedM;
    logic [1:0]  ResultSrcM, MemStrobeM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        DReq, DWe, DAck;
    logic [31:0] DAddr, DWData, DRData;
    logic [3:0]  DBe;
    logic        StallM, MisalignM, BusErrW, RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.WAIT_MAX(15)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .MemStrobeM(MemStrobeM), .LdUnsignedM(LdUnsignedM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData), .DBe(DBe),
        .DRData(DRData), .DAck(DAck),
        .StallM(StallM), .MisalignM(MisalignM), .BusErrW(BusErrW),
        .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic rw, input logic mw, input logic [1:0] rs, input logic [1:0] ms,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
        RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; MemStrobeM = ms;
        LdUnsignedM = uns; ALUResultM = addr; WriteDataM = wd; RdM = rd;
    endtask

    task automatic set_nop();
        set_op(1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 32'h0, 32'h0, 5'd0);
    endtask

    // From IDLE with a memory op presented: ack after `waits` BUSY cycles, finish in IDLE with W captured.
    task automatic run_access(input int waits, input logic [31:0] rdata);
        tick();
        for (int i = 0; i < waits; i++) tick();
        DAck = 1'b1; DRData = rdata;
        tick();
        DAck = 1'b0; DRData = 32'h0;
        tick();
        set_nop();
    endtask

    initial begin
        int n;
        int stall_cycles;
        rst = 1'b1; DAck = 1'b0; DRData = 32'h0; PCPlus4M = 32'h0;
        set_nop();
        tick(); tick();
        rst = 1'b0;
        chk("rst_regwrite", RegWriteW, 0);
        chk("rst_rd",       RdW, 0);
        chk("rst_result",   ResultW, 0);
        chk("rst_buserr",   BusErrW, 0);
        chk("rst_dreq",     DReq, 0);
        chk("rst_stall",    StallM, 0);

        // PC+4 writeback, non-memory op
        set_op(1'b1, 1'b0, 2'b10, 2'b10, 1'b0, 32'h5555_0000, 32'h0, 5'd1);
        PCPlus4M = 32'h0000_0404;
        #1 chk("pc4_stall", StallM, 0);
        tick();
        chk("pc4_result", ResultW, 32'h0000_0404);
        chk("pc4_rd",     RdW, 1);

        // ALU writeback, then a word load whose stall must insert bubbles
        set_op(1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 32'h1111_2222, 32'h0, 5'd5);
        tick();
        chk("alu_regwrite", RegWriteW, 1);
        chk("alu_rd",       RdW, 5);
        chk("alu_result",   ResultW, 32'h1111_2222);
        set_op(1'b1, 1'b0, 2'b01, 2'b10, 1'b0, 32'h0000_0008, 32'h0, 5'd6);
        tick();
        chk("bub_regwrite", RegWriteW, 0);
        chk("bub_rd",       RdW, 5);
        chk("bub_result",   ResultW, 32'h1111_2222);
        chk("lw_daddr",     DAddr, 32'h0000_0008);
        chk("lw_dwe",       DWe, 0);
        tick();
        DAck = 1'b1; DRData = 32'hCAFE_F00D;
        tick();
        DAck = 1'b0;
        tick();
        set_nop();
        chk("lw_result",   ResultW, 32'hCAFE_F00D);
        chk("lw_regwrite", RegWriteW, 1);
        chk("lw_rd",       RdW, 6);

        // Word store, acked in first BUSY cycle
        set_op(1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 5'd0);
        stall_cycles = 0;
        #1 chk("sw_idle_dreq", DReq, 0);
        stall_cycles += int'(StallM);
        tick();
        stall_cycles += int'(StallM);
        chk("sw_dreq",  DReq, 1);
        chk("sw_dwe",   DWe, 1);
        chk("sw_dbe",   DBe, 4'b1111);
        chk("sw_wdata", DWData, 32'hDEAD_BEEF);
        chk("sw_daddr", DAddr, 32'h0000_0104);
        DAck = 1'b1;
        tick();
        DAck = 1'b0;
        stall_cycles += int'(StallM);
        chk("sw_done_dbe", DBe, 0);
        chk("sw_stall_cycles", stall_cycles, 2);
        tick();
        set_nop();
        chk("sw_regwrite", RegWriteW, 0);

        // Signed and unsigned byte loads from the top lane
        set_op(1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 32'h0000_0203, 32'h0, 5'd7);
        run_access(0, 32'h80FF_FFFF);
        chk("lb_result",   ResultW, 32'hFFFF_FF80);
        chk("lb_regwrite", RegWriteW, 1);
        chk("lb_rd",       RdW, 7);
        set_op(1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 32'h0000_0203, 32'h0, 5'd7);
        run_access(0, 32'h80FF_FFFF);
        chk("lbu_result", ResultW, 32'h0000_0080);

        // Signed half load from upper lane, ack after one wait cycle
        set_op(1'b1, 1'b0, 2'b01, 2'b01, 1'b0, 32'h0000_0002, 32'h0, 5'd8);
        run_access(1, 32'h8001_1234);
        chk("lh_result", ResultW, 32'hFFFF_8001);

        // Half store to upper half, byte store to lane 1
        set_op(1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 32'h0000_0002, 32'h1234_ABCD, 5'd0);
        tick();
        chk("sh_dbe",   DBe, 4'b1100);
        chk("sh_wdata", DWData, 32'hABCD_ABCD);
        DAck = 1'b1; tick(); DAck = 1'b0; tick();
        set_op(1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 32'h0000_0001, 32'h0000_005A, 5'd0);
        tick();
        chk("sb_dbe",   DBe, 4'b0010);
        chk("sb_wdata", DWData, 32'h5A5A_5A5A);
        DAck = 1'b1; tick(); DAck = 1'b0; tick();
        set_nop();

        // Misaligned word load and misaligned half store
        set_op(1'b1, 1'b0, 2'b01, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 5'd3);
        #1 chk("mis_flag", MisalignM, 1);
        chk("mis_stall", StallM, 0);
        chk("mis_dreq",  DReq, 0);
        tick();
        chk("mis_regwrite", RegWriteW, 0);
        chk("mis_dreq_after", DReq, 0);
        set_op(1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 32'h0000_0001, 32'h0, 5'd0);
        #1 chk("mis_half_flag", MisalignM, 1);
        tick();
        set_nop();

        // Bus timeout
        set_op(1'b1, 1'b0, 2'b01, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 5'd4);
        tick();
        n = 0;
        while (DReq === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk("to_busy_cycles", n, 15);
        chk("to_done_stall",  StallM, 0);
        chk("to_done_buserr", BusErrW, 0);
        tick();
        set_nop();
        chk("to_buserr",   BusErrW, 1);
        chk("to_regwrite", RegWriteW, 0);
        tick();
        chk("to_buserr_pulse", BusErrW, 0);
        chk("to_idle_dreq",    DReq, 0);

        // Reset in the third BUSY cycle, then a stale DAck
        set_op(1'b1, 1'b0, 2'b01, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 5'd9);
        tick(); tick(); tick();
        chk("rb_busy3_dreq", DReq, 1);
        rst = 1'b1;
        set_nop();
        tick();
        rst = 1'b0;
        DAck = 1'b1; DRData = 32'h1234_5678;
        #1 chk("rb_dreq",  DReq, 0);
        chk("rb_stall",    StallM, 0);
        tick();
        DAck = 1'b0;
        chk("rb_regwrite", RegWriteW, 0);
        chk("rb_rd",       RdW, 0);
        chk("rb_result",   ResultW, 0);
        chk("rb_buserr",   BusErrW, 0);
        tick();
        chk("rb_regwrite2", RegWriteW, 0);
        chk("rb_result2",   ResultW, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
